// File: rtl/bird_pkg.sv
// bird_pkg: shared FSM encoding and default physics/geometry constants for bird_ctrl and the renderer.
package bird_pkg;
    localparam int BIRD_PW         = 7;
    localparam int BIRD_VW         = 5;
    localparam int BIRD_PMAX       = 100;
    localparam int BIRD_POS_INIT   = 50;
    localparam int BIRD_GRAV       = 1;
    localparam int BIRD_FLAP       = 6;
    localparam int BIRD_VMAX       = 7;
    localparam int BIRD_SAMPLE_CYC = 8;
    localparam int BIRD_ACK_TO     = 4;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SAMPLE = 2'd2,
        UPDATE = 2'd3
    } state_e;
endpackage

// File: rtl/bird_physics.sv
// bird_physics: combinational flap/gravity step producing next position, next velocity and a top/floor hit.
module bird_physics
    import bird_pkg::*;
#(
    parameter int PW   = BIRD_PW,
    parameter int VW   = BIRD_VW,
    parameter int PMAX = BIRD_PMAX,
    parameter int GRAV = BIRD_GRAV,
    parameter int FLAP = BIRD_FLAP,
    parameter int VMAX = BIRD_VMAX
) (
    input  logic [PW-1:0]        pos_i,
    input  logic signed [VW-1:0] vel_i,
    input  logic                 flap_i,
    output logic [PW-1:0]        pos_o,
    output logic signed [VW-1:0] vel_o,
    output logic                 hit_o
);
    localparam logic signed [VW:0]   G_V    = (VW+1)'(GRAV);
    localparam logic signed [VW:0]   VMAX_V = (VW+1)'(VMAX);
    localparam logic signed [VW:0]   FLAP_V = (VW+1)'(-FLAP);
    localparam logic signed [PW+1:0] PMAX_V = (PW+2)'(PMAX);
    logic signed [VW:0]   vg;
    logic signed [VW:0]   vn;
    logic signed [PW+1:0] ps;
    logic                 lo;
    logic                 hi;
    always_comb begin
        vg    = $signed({vel_i[VW-1], vel_i}) + G_V;
        vn    = flap_i ? FLAP_V : (vg > VMAX_V ? VMAX_V : vg);
        ps    = $signed({2'b00, pos_i}) + $signed({{(PW+1-VW){vn[VW]}}, vn});
        lo    = ps[PW+1] || ps == '0;
        hi    = ps >= PMAX_V;
        hit_o = lo || hi;
        pos_o = lo ? '0 : (hi ? PW'(PMAX) : ps[PW-1:0]);
        vel_o = vn[VW-1:0];
    end
endmodule

// File: rtl/bird_ctrl.sv
// bird_ctrl: per-frame sampler handshake plus bird physics state; BIRD_AUTOFLAP_EN forces flaps
// near the floor while running (attract mode).
module bird_ctrl
    import bird_pkg::*;
#(
    parameter int PW         = BIRD_PW,
    parameter int VW         = BIRD_VW,
    parameter int PMAX       = BIRD_PMAX,
    parameter int POS_INIT   = BIRD_POS_INIT,
    parameter int GRAV       = BIRD_GRAV,
    parameter int FLAP       = BIRD_FLAP,
    parameter int VMAX       = BIRD_VMAX,
    parameter int SAMPLE_CYC = BIRD_SAMPLE_CYC,
    parameter int ACK_TO     = BIRD_ACK_TO
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 frame_i,
    input  logic                 left_i,
    input  logic                 right_i,
    input  logic                 d_inp_i,
    output logic                 e_inp_o,
    output logic [PW-1:0]        pos_o,
    output logic signed [VW-1:0] vel_o,
    output logic                 run_o,
    output logic                 hit_o,
    output logic                 upd_o,
    output logic                 overrun_o,
    output logic                 to_o
);
    localparam int CW = $clog2((SAMPLE_CYC > ACK_TO ? SAMPLE_CYC : ACK_TO) + 1);
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic signed [VW-1:0] vel_q, vel_d;
    logic                 run_q, run_d, hit_q, hit_d, upd_q, upd_d;
    logic                 ovr_q, ovr_d, to_q, to_d, flap_q, flap_d, start_q, start_d;
    logic                 flap_eff, auto_flap;
    logic [PW-1:0]        phy_pos;
    logic signed [VW-1:0] phy_vel;
    logic                 phy_hit;
`ifdef BIRD_AUTOFLAP_EN
    assign auto_flap = run_q && pos_q >= PW'(PMAX - PMAX/4);
`else
    assign auto_flap = 1'b0;
`endif
    assign flap_eff = flap_q | auto_flap;
    bird_physics #(
        .PW(PW), .VW(VW), .PMAX(PMAX), .GRAV(GRAV), .FLAP(FLAP), .VMAX(VMAX)
    ) u_phys (
        .pos_i (pos_q),
        .vel_i (vel_q),
        .flap_i(flap_eff),
        .pos_o (phy_pos),
        .vel_o (phy_vel),
        .hit_o (phy_hit)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        run_d   = run_q;
        hit_d   = hit_q;
        to_d    = to_q;
        flap_d  = flap_q;
        start_d = start_q;
        upd_d   = 1'b0;
        ovr_d   = ovr_q | (frame_i && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (frame_i) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (d_inp_i) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(ACK_TO - 1)) begin
                    state_d = UPDATE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                flap_d  = flap_q | (d_inp_i & left_i);
                start_d = start_q | (d_inp_i & right_i);
                cnt_d   = cnt_q + 1'b1;
                if (!d_inp_i || cnt_q == CW'(SAMPLE_CYC - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
                upd_d   = 1'b1;
                flap_d  = 1'b0;
                start_d = 1'b0;
                // A start/restart consumes its frame; physics resumes on the next update.
                if (start_q && hit_q) begin
                    pos_d = PW'(POS_INIT);
                    vel_d = '0;
                    hit_d = 1'b0;
                    run_d = 1'b1;
                end else if (start_q) begin
                    run_d = !run_q;
                end else if (run_q && !hit_q) begin
                    pos_d = phy_pos;
                    vel_d = phy_vel;
                    if (phy_hit) begin
                        hit_d = 1'b1;
                        run_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= PW'(POS_INIT);
            vel_q   <= '0;
            run_q   <= 1'b0;
            hit_q   <= 1'b0;
            upd_q   <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
            flap_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            vel_q   <= vel_d;
            run_q   <= run_d;
            hit_q   <= hit_d;
            upd_q   <= upd_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
            flap_q  <= flap_d;
            start_q <= start_d;
        end
    end
    assign e_inp_o   = state_q == REQ || state_q == SAMPLE;
    assign pos_o     = pos_q;
    assign vel_o     = vel_q;
    assign run_o     = run_q;
    assign hit_o     = hit_q;
    assign upd_o     = upd_q;
    assign overrun_o = ovr_q;
    assign to_o      = to_q;
endmodule
